// File: rtl/online_softmax_acc.sv
// online_softmax_acc
//   Streaming (online) softmax accumulator for one attention row. Each accepted
//   (score, V vector) pair updates a running maximum m, a running denominator l
//   and DK weighted V accumulators. All values are rescaled whenever a new
//   maximum arrives, so the result is never recomputed. Weights are powers of two:
//   w = 2^(s - m) in FRAC fractional bits. A weight shifted down to
//   ACC_W or more bit positions is treated as exactly zero.
//
//   Optional feature: define OSM_SAT_EN to make every accumulator add and the l
//   add saturate. Without it, acc and l wrap modulo 2^ACC_W.
//
// Ports
//   clk      : clock
//   rst      : synchronous reset, active low
//   vld_in   : upstream score/V pair valid
//   rdy_out  : block can accept a pair (IDLE or ACCUM)
//   s_in     : signed scaled score, S_W bits
//   v_in     : DK packed signed V elements, V_W bits each
//   last_in  : pair is the final key of the row
//   vld_out  : row result valid (EMIT)
//   rdy_in   : downstream ready
//   o_out    : DK packed signed accumulators, ACC_W bits each
//   l_out    : unsigned softmax denominator
//   m_out    : running maximum score of the row
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. valid must not depend on ready. Data is held stable while valid is
// high and ready is low. Input pairs can stream at one per cycle. A row result
// is held in EMIT until rdy_in is seen high.

module online_softmax_acc #(
    parameter int DK    = 64,
    parameter int S_W   = 16,
    parameter int V_W   = 8,
    parameter int FRAC  = 8,
    parameter int ACC_W = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vld_in,
    output logic                       rdy_out,
    input  logic signed [S_W-1:0]      s_in,
    input  logic [DK*V_W-1:0]          v_in,
    input  logic                       last_in,
    output logic                       vld_out,
    input  logic                       rdy_in,
    output logic signed [DK*ACC_W-1:0] o_out,
    output logic [ACC_W-1:0]           l_out,
    output logic signed [S_W-1:0]      m_out
);

    // Internal arithmetic width. One guard bit is kept only when overflow has
    // to be detected for saturation.
`ifdef OSM_SAT_EN
    localparam int EW = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`else
    localparam int EW = ACC_W;
`endif

    localparam logic [ACC_W-1:0] ONE = ACC_W'(1) << FRAC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                  state;
    logic signed [S_W-1:0]   m_q;
    logic [ACC_W-1:0]        l_q;
    logic signed [ACC_W-1:0] acc_q   [DK];
    logic signed [ACC_W-1:0] acc_nxt [DK];

    logic                    accept;
    logic                    is_first;
    logic signed [S_W:0]     diff;
    logic                    new_max;
    logic [S_W:0]            d;
    logic                    flush;
    logic [ACC_W-1:0]        w;
    logic [ACC_W-1:0]        l_shift;
    logic [EW-1:0]           l_sum;
    logic [ACC_W-1:0]        l_nxt;

    // Narrow an EW-wide signed result back to ACC_W bits, clamping on overflow
    // when saturation is built in.
    function automatic logic signed [ACC_W-1:0] fit(input logic signed [EW-1:0] x);
`ifdef OSM_SAT_EN
        if (x[EW-1] != x[EW-2]) begin
            return x[EW-1] ? ACC_MIN : ACC_MAX;
        end
`endif
        return x[ACC_W-1:0];
    endfunction

    // Next value of one accumulator lane.
    function automatic logic signed [ACC_W-1:0] lane_next(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [V_W-1:0]   v,
        input logic                    first_key,
        input logic                    grow,
        input logic                    flush_old,
        input logic [S_W:0]            shamt,
        input logic [ACC_W-1:0]        wt
    );
        logic signed [EW-1:0] v_ext;
        logic signed [EW-1:0] v_sh;
        logic signed [EW-1:0] acc_ext;
        logic signed [EW-1:0] acc_sh;
        logic signed [EW-1:0] w_ext;
        v_ext   = EW'(v);
        v_sh    = v_ext <<< FRAC;
        acc_ext = EW'(acc);
        // An arithmetic shift of a negative value would saturate at -1. A flushed
        // history must contribute exactly zero.
        acc_sh  = flush_old ? '0 : (acc_ext >>> shamt);
        w_ext   = EW'($signed({1'b0, wt}));
        if (first_key) begin
            return fit(v_sh);
        end else if (grow) begin
            return fit(acc_sh + v_sh);
        end else begin
            return fit(acc_ext + v_ext * w_ext);
        end
    endfunction

    assign accept   = vld_in && rdy_out;
    assign is_first = (state == IDLE);

    always_comb begin
        diff    = {s_in[S_W-1], s_in} - {m_q[S_W-1], m_q};
        new_max = !diff[S_W] && (diff != '0);
        // d is the magnitude of the score gap. It is nonnegative on both branches.
        d       = new_max ? $unsigned(diff) : $unsigned(-diff);
        flush   = (d >= (S_W+1)'(ACC_W));
        w       = flush ? '0 : (ONE >> d);
        l_shift = flush ? '0 : (l_q >> d);

        if (is_first) begin
            l_sum = EW'(ONE);
        end else if (new_max) begin
            l_sum = EW'(l_shift) + EW'(ONE);
        end else begin
            l_sum = EW'(l_q) + EW'(w);
        end
`ifdef OSM_SAT_EN
        l_nxt = l_sum[EW-1] ? '1 : l_sum[ACC_W-1:0];
`else
        l_nxt = l_sum;
`endif

        for (int i = 0; i < DK; i++) begin
            acc_nxt[i] = lane_next(acc_q[i], v_in[i*V_W +: V_W], is_first,
                                   new_max, flush, d, w);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            m_q     <= '0;
            l_q     <= '0;
            rdy_out <= 1'b1;
            vld_out <= 1'b0;
            for (int i = 0; i < DK; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (is_first || new_max) begin
                            m_q <= s_in;
                        end
                        l_q <= l_nxt;
                        for (int i = 0; i < DK; i++) begin
                            acc_q[i] <= acc_nxt[i];
                        end
                        if (last_in) begin
                            state   <= EMIT;
                            rdy_out <= 1'b0;
                            vld_out <= 1'b1;
                        end else begin
                            state   <= ACCUM;
                        end
                    end
                end
                EMIT: begin
                    if (rdy_in) begin
                        state   <= IDLE;
                        rdy_out <= 1'b1;
                        vld_out <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rdy_out <= 1'b1;
                    vld_out <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_out = '0;
        for (int i = 0; i < DK; i++) begin
            o_out[i*ACC_W +: ACC_W] = acc_q[i];
        end
    end

    assign l_out = l_q;
    assign m_out = m_q;

endmodule

// File: tb/tb_online_softmax_acc.sv
module tb_online_softmax_acc;
    localparam int DK    = 64;
    localparam int S_W   = 16;
    localparam int V_W   = 8;
    localparam int FRAC  = 8;
    localparam int ACC_W = 24;

    logic                 clk     = 1'b0;
    logic                 rst     = 1'b0;
    logic                 vld_in  = 1'b0;
    logic                 last_in = 1'b0;
    logic                 rdy_in  = 1'b1;
    logic [S_W-1:0]       s_in    = '0;
    logic [DK*V_W-1:0]    v_in    = '0;
    logic                 rdy_out;
    logic                 vld_out;
    logic [DK*ACC_W-1:0]  o_out;
    logic [ACC_W-1:0]     l_out;
    logic [S_W-1:0]       m_out;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_o [DK];

    // clock / reset
    always #5 clk = ~clk;

    online_softmax_acc #(
        .DK(DK), .S_W(S_W), .V_W(V_W), .FRAC(FRAC), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
        .s_in(s_in), .v_in(v_in), .last_in(last_in), .vld_out(vld_out),
        .rdy_in(rdy_in), .o_out(o_out), .l_out(l_out), .m_out(m_out)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DK*V_W-1:0] fill(input int val);
        logic [DK*V_W-1:0] r;
        for (int i = 0; i < DK; i++) r[i*V_W +: V_W] = V_W'(val);
        return r;
    endfunction

    function automatic void set_exp_all(input int val);
        for (int i = 0; i < DK; i++) exp_o[i] = val;
    endfunction

    // driver: one pair per call, back-to-back calls give a bubble-free stream
    task automatic send(input int s, input logic [DK*V_W-1:0] v, input logic last);
        s_in    = S_W'(s);
        v_in    = v;
        last_in = last;
        vld_in  = 1'b1;
        @(posedge clk); #1;
        vld_in  = 1'b0;
        last_in = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input int exp_l, input int exp_m);
        check({tag, "_vld"}, vld_out, 1);
        check({tag, "_rdy"}, rdy_out, 0);
        for (int i = 0; i < DK; i++)
            check($sformatf("%s_o%0d", tag, i), $signed(o_out[i*ACC_W +: ACC_W]), exp_o[i]);
        check({tag, "_l"}, l_out, exp_l);
        check({tag, "_m"}, $signed(m_out), exp_m);
    endtask

    // called right after the last pair: result must be visible now
    task automatic finish_row(input string tag, input int exp_l, input int exp_m);
        check_outputs(tag, exp_l, exp_m);
        @(posedge clk); #1;
        check({tag, "_ret_vld"}, vld_out, 0);
        check({tag, "_ret_rdy"}, rdy_out, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_vld"}, vld_out, 0);
        check({tag, "_rdy"}, rdy_out, 1);
        check({tag, "_o0"}, $signed(o_out[ACC_W-1:0]), 0);
        check({tag, "_oN"}, $signed(o_out[DK*ACC_W-1 -: ACC_W]), 0);
        check({tag, "_l"}, l_out, 0);
        check({tag, "_m"}, $signed(m_out), 0);
    endtask

    initial begin
        int exp_big;
        logic [DK*V_W-1:0] ramp;

        // reset
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_reset_state("reset");
        rst = 1'b1;

        // equal scores
        send(4, fill(1), 1'b0);
        send(4, fill(1), 1'b1);
        set_exp_all(512);
        finish_row("eq", 512, 4);

        // later key is the new max
        send(2, fill(2), 1'b0);
        send(5, fill(1), 1'b1);
        set_exp_all(320);
        finish_row("grow", 288, 5);

        // earlier key is the max
        send(5, fill(1), 1'b0);
        send(2, fill(2), 1'b1);
        set_exp_all(320);
        finish_row("shrink", 288, 5);

        // gap beyond ACC_W flushes the history
        send(0, fill(3), 1'b0);
        send(40, fill(-1), 1'b1);
        set_exp_all(-256);
        finish_row("flush", 256, 40);

        // negative scores and V
        send(-1, fill(-2), 1'b0);
        send(-4, fill(4), 1'b1);
        set_exp_all(-384);
        finish_row("neg", 288, -1);

        // three keys: grow then smaller
        send(1, fill(4), 1'b0);
        send(3, fill(2), 1'b0);
        send(2, fill(8), 1'b1);
        set_exp_all(1792);
        finish_row("three", 448, 3);

        // single key row with per-lane distinct V
        for (int i = 0; i < DK; i++) begin
            ramp[i*V_W +: V_W] = V_W'(i - 32);
            exp_o[i] = (i - 32) * 256;
        end
        send(7, ramp, 1'b1);
        finish_row("single", 256, 7);

        // long row: accumulator overflow
        for (int k = 0; k < 259; k++) send(3, fill(127), (k == 258));
`ifdef OSM_SAT_EN
        exp_big = 8388607;
`else
        exp_big = -8356608;
`endif
        set_exp_all(exp_big);
        finish_row("long", 66304, 3);

        // backpressure: hold 5 cycles while junk is offered upstream
        rdy_in = 1'b0;
        send(2, fill(2), 1'b0);
        send(5, fill(1), 1'b1);
        for (int k = 0; k < 5; k++) begin
            s_in = S_W'(100); v_in = fill(50); last_in = 1'b1; vld_in = 1'b1;
            check($sformatf("stall%0d_vld", k), vld_out, 1);
            check($sformatf("stall%0d_rdy", k), rdy_out, 0);
            check($sformatf("stall%0d_o0", k), $signed(o_out[ACC_W-1:0]), 320);
            check($sformatf("stall%0d_oN", k), $signed(o_out[DK*ACC_W-1 -: ACC_W]), 320);
            check($sformatf("stall%0d_l", k), l_out, 288);
            check($sformatf("stall%0d_m", k), $signed(m_out), 5);
            @(posedge clk); #1;
        end
        vld_in = 1'b0; last_in = 1'b0;
        rdy_in = 1'b1;
        set_exp_all(320);
        finish_row("stall_end", 288, 5);

        // reset mid-row discards the partial row
        send(10, fill(5), 1'b0);
        send(12, fill(7), 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("midrst");
        rst = 1'b1;
        send(2, fill(2), 1'b0);
        send(5, fill(1), 1'b1);
        set_exp_all(320);
        finish_row("after_rst", 288, 5);

        // reset while holding a result in EMIT
        rdy_in = 1'b0;
        send(9, fill(3), 1'b1);
        check("emitrst_pre_vld", vld_out, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("emitrst");
        rst = 1'b1;
        rdy_in = 1'b1;
        send(4, fill(1), 1'b0);
        send(4, fill(1), 1'b1);
        set_exp_all(512);
        finish_row("after_emitrst", 512, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
